// File: rtl/tdc_seq.sv
// Sequencer for a ring-oscillator TDC: clear, arm, run the selected oscillator
// for a window, let it settle, then capture the sampled buffer value.
module tdc_seq #(
  parameter int SETTLE_CYC = 4,
  parameter int SAMPLE_W   = 19
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          ro_sel,
  input  logic [7:0]          window,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [1:0]          byte_sel,
  output logic                ro_activate,
  output logic                ro_deactivate,
  output logic [2:0]          out_sel,
  output logic                busy,
  output logic                done,
  output logic                valid,
  output logic [7:0]          dout
);

  typedef enum logic [2:0] {IDLE, CLEAR, ARM, ACTIVE, SETTLE, CAPTURE} state_t;

  state_t              state, state_n;
  logic [7:0]          cnt;
  logic [7:0]          win_q;
  logic [SAMPLE_W-1:0] result;
  logic [7:0]          meas_cnt;
  logic [23:0]         res_ext;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = CLEAR;
      CLEAR:   state_n = ARM;
      ARM:     state_n = ACTIVE;
      ACTIVE:  if (cnt == 8'd0) state_n = SETTLE;
      SETTLE:  if (cnt == 8'd0) state_n = CAPTURE;
      CAPTURE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet
  // aligned with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      win_q         <= 8'd0;
      out_sel       <= 3'd0;
      ro_activate   <= 1'b0;
      ro_deactivate <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      valid         <= 1'b0;
      result        <= '0;
      meas_cnt      <= 8'd0;
    end else begin
      state         <= state_n;
      ro_activate   <= (state_n == ACTIVE);
      ro_deactivate <= (state_n == CLEAR);
      busy          <= (state_n != IDLE);
      done          <= (state_n == CAPTURE);
      if (state == IDLE && start) begin
        out_sel <= ro_sel;
        win_q   <= window;
      end
      // cnt holds remaining cycles minus one for the current timed state
      if (state == ARM)
        cnt <= (win_q == 8'd0) ? 8'd0 : win_q - 8'd1;
      else if (state == ACTIVE && cnt == 8'd0)
        cnt <= 8'(SETTLE_CYC - 1);
      else if (cnt != 8'd0)
        cnt <= cnt - 8'd1;
      if (state_n == CAPTURE) begin
        result <= sample;
        valid  <= 1'b1;
        if (meas_cnt != 8'hFF) meas_cnt <= meas_cnt + 8'd1;
      end
    end
  end

  assign res_ext = 24'(result);

  always_comb begin
    dout = 8'd0;
    case (byte_sel)
      2'd0: dout = res_ext[7:0];
      2'd1: dout = res_ext[15:8];
      2'd2: dout = {5'b0, res_ext[18:16]};
      2'd3: dout = meas_cnt;
      default: dout = 8'd0;
    endcase
  end

endmodule

// File: tb/tb_tdc_seq.sv
// Bench for tdc_seq: vector table, random runs against a latency/result model,
// plus hand sequences for ignored starts, mid-run reset and back-to-back runs.
module tb_tdc_seq;
  localparam int S = 4;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [2:0]  ro_sel = '0;
  logic [7:0]  window = '0;
  logic [18:0] sample = '0;
  logic [1:0]  byte_sel = '0;
  logic        ro_activate, ro_deactivate, busy, done, valid;
  logic [2:0]  out_sel;
  logic [7:0]  dout;

  int tests = 0, fails = 0, model_cnt = 0;

  tdc_seq #(.SETTLE_CYC(S), .SAMPLE_W(19)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ro_sel(ro_sel), .window(window),
    .sample(sample), .byte_sel(byte_sel), .ro_activate(ro_activate),
    .ro_deactivate(ro_deactivate), .out_sel(out_sel), .busy(busy), .done(done),
    .valid(valid), .dout(dout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [2:0]  sel;
    logic [7:0]  win;
    logic [18:0] smp;
    int          lat;
    int          act;
    logic [7:0]  d0, d1, d2;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int model_lat(input logic [7:0] w);
    return 3 + ((w == 8'd0) ? 1 : int'(w)) + S;
  endfunction

  function automatic int model_act(input logic [7:0] w);
    return (w == 8'd0) ? 1 : int'(w);
  endfunction

  // called right after a negedge; all four reads finish before the next posedge
  task automatic check_dout(input string tag, input logic [7:0] e0, e1, e2, e3);
    logic [7:0] e[4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int b = 0; b < 4; b++) begin
      byte_sel = 2'(b);
      #1;
      check($sformatf("%s dout[%0d]", tag, b), 32'(dout), 32'(e[b]));
    end
  endtask

  // Caller is at a negedge; start is presented for the next edge.
  // Start is re-pulsed on cycles p1/p2 to verify it is ignored while busy.
  task automatic run_meas(input logic [2:0] sel, input logic [7:0] win, input logic [18:0] smp,
                          input int p1, input int p2,
                          output int dcyc, output int act, output int deact, output int bad);
    start = 1'b1; ro_sel = sel; window = win; sample = smp;
    dcyc = -1; act = 0; deact = 0; bad = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      start = (c == p1) || (c == p2);
      ro_sel = ~sel; window = ~win;
      if (ro_activate === 1'b1) act++;
      if (ro_deactivate === 1'b1) deact++;
      if (out_sel !== sel || busy !== 1'b1 || (ro_activate && ro_deactivate)) bad++;
      if (done === 1'b1) begin
        dcyc = c;
        break;
      end
    end
    start = 1'b0;
    if (dcyc > 0 && model_cnt < 255) model_cnt++;
  endtask

  task automatic full_run(input string tag, input logic [2:0] sel, input logic [7:0] win,
                          input logic [18:0] smp, input int exp_lat, input int exp_act,
                          input logic [7:0] d0, d1, d2);
    int dc, ac, de, bd;
    run_meas(sel, win, smp, 0, 0, dc, ac, de, bd);
    check({tag, " latency"}, 32'(dc), 32'(exp_lat));
    check({tag, " active cycles"}, 32'(ac), 32'(exp_act));
    check({tag, " clear cycles"}, 32'(de), 32'd1);
    check({tag, " sel/busy/overlap errs"}, 32'(bd), 32'd0);
    check_dout(tag, d0, d1, d2, 8'(model_cnt));
    @(negedge clk);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " done pulse width"}, 32'(done), 32'd0);
    check({tag, " valid"}, 32'(valid), 32'd1);
  endtask

  initial begin
    int dc, ac, de, bd, n, last, badsp, ovl, dn;
    logic [7:0]  w;
    logic [2:0]  sl;
    logic [18:0] sm;

    vecs[0] = '{3'd5, 8'd10,  19'h5A5A5, 17,  10,  8'hA5, 8'hA5, 8'h05};
    vecs[1] = '{3'd3, 8'd0,   19'h12345, 8,   1,   8'h45, 8'h23, 8'h01};
    vecs[2] = '{3'd7, 8'd255, 19'h7FFFF, 262, 255, 8'hFF, 8'hFF, 8'h07};
    vecs[3] = '{3'd0, 8'd1,   19'h00100, 8,   1,   8'h00, 8'h01, 8'h00};

    repeat (2) @(negedge clk);
    check("reset ro_activate", 32'(ro_activate), 32'd0);
    check("reset ro_deactivate", 32'(ro_deactivate), 32'd0);
    check("reset out_sel", 32'(out_sel), 32'd0);
    check("reset busy/done/valid", {29'd0, busy, done, valid}, 32'd0);
    check_dout("reset", 8'd0, 8'd0, 8'd0, 8'd0);

    // release and start in the same cycle: first edge with rst_n=1 accepts
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      full_run($sformatf("vec%0d", i), vecs[i].sel, vecs[i].win, vecs[i].smp,
               vecs[i].lat, vecs[i].act, vecs[i].d0, vecs[i].d1, vecs[i].d2);

    // start pulses in ACTIVE (cycle 5) and SETTLE (cycle 14) must be dropped
    run_meas(3'd2, 8'd10, 19'h0BEEF, 5, 14, dc, ac, de, bd);
    check("ignored-start latency", 32'(dc), 32'd17);
    check("ignored-start active", 32'(ac), 32'd10);
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dn++;
    end
    check("ignored-start no rerun", 32'(dn), 32'd0);
    check_dout("ignored-start", 8'hEF, 8'hBE, 8'h00, 8'(model_cnt));

    for (int r = 0; r < 15; r++) begin
      w  = 8'($urandom_range(0, 30));
      sl = 3'($urandom);
      sm = 19'($urandom);
      full_run($sformatf("rand%0d", r), sl, w, sm, model_lat(w), model_act(w),
               sm[7:0], sm[15:8], {5'd0, sm[18:16]});
    end

    // reset during the 5th ACTIVE cycle (cycle 7 after start)
    start = 1'b1; ro_sel = 3'd6; window = 8'd10; sample = 19'h11111;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("mid-run ro_activate before reset", 32'(ro_activate), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset ro_activate", 32'(ro_activate), 32'd0);
    check("async reset outs", {25'd0, ro_deactivate, out_sel, busy, done, valid}, 32'd0);
    byte_sel = 2'd3;
    #1 check("async reset meas_cnt", 32'(dout), 32'd0);
    model_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done === 1'b1 || ro_activate === 1'b1) dn++;
    end
    check("no done after reset", 32'(dn), 32'd0);

    // back-to-back runs with start held: 300 captures, one IDLE cycle between
    start = 1'b1; window = 8'd0; ro_sel = 3'd4; sample = 19'h2468A;
    n = 0; last = 0; badsp = 0; ovl = 0;
    for (int c = 1; c <= 300 * 9 + 50; c++) begin
      @(negedge clk);
      if (ro_activate && ro_deactivate) ovl++;
      if (done === 1'b1) begin
        n++;
        if (n > 1 && c - last != model_lat(8'd0) + 1) badsp++;
        last = c;
        if (model_cnt < 255) model_cnt++;
        if (n == 300) begin
          start = 1'b0;
          break;
        end
      end
    end
    check("continuous run count", 32'(n), 32'd300);
    check("continuous spacing errs", 32'(badsp), 32'd0);
    check("continuous overlap", 32'(ovl), 32'd0);
    check_dout("saturated", 8'h8A, 8'h46, 8'h02, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
